robs_divider: RTL and testbench

Sequential signed divider for the shift-add arithmetic group, the division counterpart of the Robertson's signed multiplier. It accepts two's-complement dividend and divisor operands on a start pulse, runs a WIDTH-step restoring division on operand magnitudes, applies sign correction, and returns quotient and remainder with a one-cycle done pulse. Control FSM, iteration counter and datapath registers are contained in the block.

---
 rtl/robs_divider.sv | 157 +++++++++++++++
 tb/tb_robs_divider.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/robs_divider.sv
// Sequential signed divider: WIDTH-step restoring division on operand magnitudes,
// then sign correction. Quotient truncates toward zero and the remainder follows the dividend's sign.
module robs_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int KW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] qm_q, qm_d, dvs_q, dvs_d, dvd_q, dvd_d;
  logic             sq_q, sq_d, sr_q, sr_d, dz_q, dz_d, ovp_q, ovp_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             dbz_q, dbz_d, ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
  logic [WIDTH+1:0] trial;

  // Shift {P,Qm} left and subtract the divisor in one step; the MSB is the sign of T.
  assign trial = {p_q, qm_q[WIDTH-1]} - {2'b00, dvs_q};

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: each always_comb assigns defaults first so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ITER;
      ITER:    if (k_q == KW'(1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d == ITER) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_comb begin
    k_d    = k_q;
    p_d    = p_q;
    qm_d   = qm_q;
    dvs_d  = dvs_q;
    dvd_d  = dvd_q;
    sq_d   = sq_q;
    sr_d   = sr_q;
    dz_d   = dz_q;
    ovp_d  = ovp_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    ovf_d  = ovf_q;
    unique case (state_q)
      IDLE: if (start) begin
        dvd_d = dividend;
        dvs_d = mag(divisor);
        qm_d  = mag(dividend);
        sq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
        sr_d  = dividend[WIDTH-1];
        dz_d  = (divisor == '0);
        ovp_d = (dividend == MIN_VAL) && (divisor == '1);
        p_d   = '0;
        k_d   = KW'(WIDTH);
      end
      ITER: begin
        k_d = k_q - KW'(1);
        if (!trial[WIDTH+1]) begin
          p_d  = trial[WIDTH:0];
          qm_d = {qm_q[WIDTH-2:0], 1'b1};
        end else begin
          p_d  = {p_q[WIDTH-1:0], qm_q[WIDTH-1]};
          qm_d = {qm_q[WIDTH-2:0], 1'b0};
        end
      end
      FIX: begin
        if (dz_q) begin
          quot_d = '1;
          rem_d  = dvd_q;
        end else begin
          quot_d = sq_q ? -qm_q : qm_q;
          rem_d  = sr_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        end
        dbz_d = dz_q;
        ovf_d = ovp_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q    <= '0;
      p_q    <= '0;
      qm_q   <= '0;
      dvs_q  <= '0;
      dvd_q  <= '0;
      sq_q   <= 1'b0;
      sr_q   <= 1'b0;
      dz_q   <= 1'b0;
      ovp_q  <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      k_q    <= k_d;
      p_q    <= p_d;
      qm_q   <= qm_d;
      dvs_q  <= dvs_d;
      dvd_q  <= dvd_d;
      sq_q   <= sq_d;
      sr_q   <= sr_d;
      dz_q   <= dz_d;
      ovp_q  <= ovp_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
      ovf_q  <= ovf_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_robs_divider.sv
// Self-checking bench for robs_divider: directed corner cases plus a random sweep
// compared against C-style truncating division computed with integer arithmetic.
module tb_robs_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         busy, done, div_by_zero, overflow;

  int errors = 0, checks = 0;
  int cyc = 0, done_cnt = 0, ops_done = 0, prev_accept = -100;
  bit overlap_seen = 1'b0;

  robs_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy && done) overlap_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int a, input int b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output logic ov);
    int minv;
    int qi;
    int ri;
    minv = -(1 << (W-1));
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      q  = '1;
      r  = a[W-1:0];
      dz = 1'b1;
    end else if (a == minv && b == -1) begin
      q  = minv[W-1:0];
      r  = '0;
      ov = 1'b1;
    end else begin
      qi = a / b;
      ri = a % b;
      q  = qi[W-1:0];
      r  = ri[W-1:0];
    end
  endfunction

  function automatic int pick();
    logic signed [W-1:0] v;
    v = W'($urandom);
    case ($urandom_range(0, 7))
      0:       return -(1 << (W-1));
      1:       return -1;
      2:       return 0;
      3:       return 1;
      4:       return (1 << (W-1)) - 1;
      default: return int'(v);
    endcase
  endfunction

  // Runs one division; inj1/inj2 are edge numbers after acceptance at which a stray start is pulsed.
  task automatic run_op(input int a, input int b, input bit b2b,
                        input int inj1, input int inj2, input string tag);
    logic [W-1:0] eq, er;
    logic         edz, eov;
    int           waited, n;
    bit           busy_drop;
    model(a, b, eq, er, edz, eov);
    if (!b2b) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    dividend = a[W-1:0];
    divisor  = b[W-1:0];
    start    = 1'b1;
    waited   = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!busy && waited < 6);
    check({tag, "/accept"}, busy, 1);
    if (b2b) check({tag, "/interval"}, cyc - prev_accept, W + 3);
    prev_accept = cyc;
    n = 0;
    busy_drop = 1'b0;
    while (!done && n < 40) begin
      start    = (n + 1 == inj1) || (n + 1 == inj2);
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(posedge clk); #1;
      n++;
      if (!done && !busy) busy_drop = 1'b1;
    end
    start = 1'b0;
    check({tag, "/latency"}, n, W + 1);
    check({tag, "/busy_drop"}, busy_drop, 0);
    check({tag, "/busy_at_done"}, busy, 0);
    check({tag, "/quotient"}, quotient, eq);
    check({tag, "/remainder"}, remainder, er);
    check({tag, "/div_by_zero"}, div_by_zero, edz);
    check({tag, "/overflow"}, overflow, eov);
    ops_done++;
  endtask

  task automatic reset_test();
    int done_before;
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rst/accept", busy, 1);
    repeat (4) @(posedge clk);
    #3;
    done_before = done_cnt;
    reset = 1'b1;
    #1;
    check("rst/quotient", quotient, 0);
    check("rst/remainder", remainder, 0);
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/div_by_zero", div_by_zero, 0);
    check("rst/overflow", overflow, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("rst/no_done", done_cnt, done_before);
    check("rst/idle_busy", busy, 0);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #2;
    reset = 1'b1;
    #1;
    check("init/quotient", quotient, 0);
    check("init/remainder", remainder, 0);
    check("init/busy", busy, 0);
    check("init/done", done, 0);
    check("init/flags", {div_by_zero, overflow}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_op( 100,  7, 1'b0, 0, 0, "p100_p7");
    run_op(-100,  7, 1'b1, 0, 0, "m100_p7");
    run_op( 100, -7, 1'b1, 0, 0, "p100_m7");
    run_op(-100, -7, 1'b1, 0, 0, "m100_m7");
    run_op(-128, -1, 1'b0, 0, 0, "ovf");
    run_op(-128,  1, 1'b0, 0, 0, "m128_p1");
    run_op( 127, -128, 1'b0, 0, 0, "p127_m128");
    run_op(   5,  0, 1'b0, 0, 0, "dbz");
    run_op(   9,  3, 1'b0, 0, 0, "p9_p3");
    run_op(  50,  8, 1'b0, 3, 9, "ignore_start");
    @(posedge clk); #1;
    check("ignore_start/no_queue", busy, 0);

    reset_test();
    run_op(-7, 2, 1'b0, 0, 0, "after_reset");

    for (int i = 0; i < 150; i++) begin
      run_op(pick(), pick(), bit'($urandom_range(0, 1)), 0, 0, "rand");
    end

    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt, ops_done);
    check("busy_done_overlap", overlap_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
